// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between the control sequencer and its datapath.
// The sequencer uses modport master; the datapath (or a bench) uses slave.
interface control_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        mem_ready;

    logic        pco;
    logic        pci;
    logic        incpc;
    logic        mari;
    logic        mdri;
    logic        mdro;
    logic        read;
    logic        iri;
    logic        ryi;
    logic        zi;
    logic        zlo;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rin;
    logic        rout;
    logic [2:0]  alu_op;
    logic        run;

    modport master (
        input  start, ir, mem_ready,
        output pco, pci, incpc, mari, mdri, mdro, read, iri, ryi, zi, zlo,
        output gra, grb, grc, rin, rout, alu_op, run
    );

    modport slave (
        output start, ir, mem_ready,
        input  pco, pci, incpc, mari, mdri, mdro, read, iri, ryi, zi, zlo,
        input  gra, grb, grc, rin, rout, alu_op, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), register-register ALU execute (T3-T5), HALT.
// Optional macro MEM_WAIT_EN stretches T1 until mem_ready is high.
module control_sequencer (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_HALT  = 4'd7
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NOP  = 5'b11011;
    localparam logic [4:0] OP_HALT = 5'b11100;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    state_t     state_reg;
    state_t     state_next;
    logic [4:0] opcode;
    logic       op_is_alu;
    logic [2:0] alu_sel;
    logic       t1_done;

    assign opcode = bus.ir[31:27];

    always_comb begin
        op_is_alu = 1'b0;
        alu_sel   = ALU_NONE;
        case (opcode)
            OP_ADD: begin op_is_alu = 1'b1; alu_sel = ALU_ADD; end
            OP_SUB: begin op_is_alu = 1'b1; alu_sel = ALU_SUB; end
            OP_AND: begin op_is_alu = 1'b1; alu_sel = ALU_AND; end
            OP_OR:  begin op_is_alu = 1'b1; alu_sel = ALU_OR;  end
            default: begin op_is_alu = 1'b0; alu_sel = ALU_NONE; end
        endcase
    end

`ifdef MEM_WAIT_EN
    assign t1_done = bus.mem_ready;
`else
    assign t1_done = 1'b1;
`endif

    // State register; clear overrides every other input.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_RESET;
        case (state_reg)
            ST_RESET: state_next = bus.start ? ST_T0 : ST_RESET;
            ST_T0:    state_next = ST_T1;
            ST_T1:    state_next = t1_done ? ST_T2 : ST_T1;
            ST_T2: begin
                if (op_is_alu) begin
                    state_next = ST_T3;
                end else if (opcode == OP_HALT) begin
                    state_next = ST_HALT;
                end else begin
                    // OP_NOP and every undefined opcode fall back to fetch.
                    state_next = ST_T0;
                end
            end
            ST_T3:    state_next = ST_T4;
            ST_T4:    state_next = ST_T5;
            ST_T5:    state_next = ST_T0;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_RESET;
        endcase
    end

    // Output decode: only one of pco/mdro/zlo/rout drives the bus per state.
    always_comb begin
        bus.pco    = 1'b0;
        bus.pci    = 1'b0;
        bus.incpc  = 1'b0;
        bus.mari   = 1'b0;
        bus.mdri   = 1'b0;
        bus.mdro   = 1'b0;
        bus.read   = 1'b0;
        bus.iri    = 1'b0;
        bus.ryi    = 1'b0;
        bus.zi     = 1'b0;
        bus.zlo    = 1'b0;
        bus.gra    = 1'b0;
        bus.grb    = 1'b0;
        bus.grc    = 1'b0;
        bus.rin    = 1'b0;
        bus.rout   = 1'b0;
        bus.alu_op = ALU_NONE;
        bus.run    = 1'b0;
        case (state_reg)
            ST_T0: begin
                bus.run   = 1'b1;
                bus.pco   = 1'b1;
                bus.mari  = 1'b1;
                bus.incpc = 1'b1;
                bus.zi    = 1'b1;
            end
            ST_T1: begin
                bus.run  = 1'b1;
                bus.read = 1'b1;
                bus.mdri = 1'b1;
                bus.zlo  = t1_done;
                bus.pci  = t1_done;
            end
            ST_T2: begin
                bus.run  = 1'b1;
                bus.mdro = 1'b1;
                bus.iri  = 1'b1;
            end
            ST_T3: begin
                bus.run  = 1'b1;
                bus.grb  = 1'b1;
                bus.rout = 1'b1;
                bus.ryi  = 1'b1;
            end
            ST_T4: begin
                bus.run    = 1'b1;
                bus.grc    = 1'b1;
                bus.rout   = 1'b1;
                bus.zi     = 1'b1;
                bus.alu_op = alu_sel;
            end
            ST_T5: begin
                bus.run = 1'b1;
                bus.zlo = 1'b1;
                bus.gra = 1'b1;
                bus.rin = 1'b1;
            end
            default: begin
                bus.run = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer; expected strobe patterns are hand-built per state.
module tb_control_sequencer;

    logic clock;
    logic clear;
    control_sequencer_if bus ();

    control_sequencer u_dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    localparam logic [19:0] B_ROUT  = 20'h00001;
    localparam logic [19:0] B_RIN   = 20'h00002;
    localparam logic [19:0] B_GRC   = 20'h00004;
    localparam logic [19:0] B_GRB   = 20'h00008;
    localparam logic [19:0] B_GRA   = 20'h00010;
    localparam logic [19:0] B_ZLO   = 20'h00020;
    localparam logic [19:0] B_ZI    = 20'h00040;
    localparam logic [19:0] B_RYI   = 20'h00080;
    localparam logic [19:0] B_IRI   = 20'h00100;
    localparam logic [19:0] B_READ  = 20'h00200;
    localparam logic [19:0] B_MDRO  = 20'h00400;
    localparam logic [19:0] B_MDRI  = 20'h00800;
    localparam logic [19:0] B_MARI  = 20'h01000;
    localparam logic [19:0] B_INCPC = 20'h02000;
    localparam logic [19:0] B_PCI   = 20'h04000;
    localparam logic [19:0] B_PCO   = 20'h08000;
    localparam logic [19:0] B_RUN   = 20'h80000;

    localparam logic [19:0] E_RESET = 20'h00000;
    localparam logic [19:0] E_T0 = B_RUN | B_PCO | B_MARI | B_INCPC | B_ZI;
    localparam logic [19:0] E_T1 = B_RUN | B_ZLO | B_PCI | B_READ | B_MDRI;
    localparam logic [19:0] E_T1_WAIT = B_RUN | B_READ | B_MDRI;
    localparam logic [19:0] E_T2 = B_RUN | B_MDRO | B_IRI;
    localparam logic [19:0] E_T3 = B_RUN | B_GRB | B_ROUT | B_RYI;
    localparam logic [19:0] E_T4 = B_RUN | B_GRC | B_ROUT | B_ZI;
    localparam logic [19:0] E_T5 = B_RUN | B_ZLO | B_GRA | B_RIN;

    function automatic logic [19:0] outs();
        return {bus.run, bus.alu_op, bus.pco, bus.pci, bus.incpc, bus.mari,
                bus.mdri, bus.mdro, bus.read, bus.iri, bus.ryi, bus.zi, bus.zlo,
                bus.gra, bus.grb, bus.grc, bus.rin, bus.rout};
    endfunction

    function automatic logic [19:0] t4_with(input logic [2:0] alu);
        return E_T4 | {1'b0, alu, 16'h0000};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Clear, load ir and start; returns one cycle into T0.
    task automatic go_t0(input logic [31:0] instr, input logic ready);
        clear = 1'b1;
        bus.start = 1'b0;
        bus.ir = instr;
        bus.mem_ready = ready;
        step();
        clear = 1'b0;
        bus.start = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [19:0] got;
        clear = 1'b1;
        bus.start = 1'b0;
        bus.ir = 32'h0;
        bus.mem_ready = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            got = outs();
            checks++;
            if (got !== E_RESET) $display("FAIL reset_idle cycle %0d: got %h want %h", i, got, E_RESET);
            else passed++;
            step();
        end
        $display("txn reset: clear then idle start=0");
    endtask

    task automatic test_add();
        logic [19:0] got;
        logic [19:0] exp_seq [7];
        exp_seq[0] = E_T0;
        exp_seq[1] = E_T1;
        exp_seq[2] = E_T2;
        exp_seq[3] = E_T3;
        exp_seq[4] = t4_with(3'd1);
        exp_seq[5] = E_T5;
        exp_seq[6] = E_T0;
        go_t0(32'h18000000, 1'b1);
        for (int i = 0; i < 7; i++) begin
            got = outs();
            checks++;
            if (got !== exp_seq[i]) $display("FAIL add_seq cycle %0d: got %h want %h", i, got, exp_seq[i]);
            else passed++;
            step();
        end
        $display("txn add: ir=18000000");
    endtask

    task automatic test_alu_ops();
        logic [19:0] got;
        logic [31:0] irs  [3];
        logic [2:0]  alus [3];
        irs[0] = 32'h20000000; alus[0] = 3'd2;
        irs[1] = 32'h28918000; alus[1] = 3'd3;
        irs[2] = 32'h30000000; alus[2] = 3'd4;
        for (int k = 0; k < 3; k++) begin
            go_t0(irs[k], 1'b1);
            for (int i = 0; i < 4; i++) step();
            got = outs();
            checks++;
            if (got !== t4_with(alus[k])) $display("FAIL alu_t4 ir=%h: got %h want %h", irs[k], got, t4_with(alus[k]));
            else passed++;
            step();
            got = outs();
            checks++;
            if (got !== E_T5) $display("FAIL alu_t5 ir=%h: got %h want %h", irs[k], got, E_T5);
            else passed++;
            $display("txn alu: ir=%h alu_op=%0d", irs[k], alus[k]);
        end
    endtask

    task automatic test_nop();
        logic [19:0] got;
        logic [19:0] exp_seq [4];
        exp_seq[0] = E_T1;
        exp_seq[1] = E_T2;
        exp_seq[2] = E_T0;
        exp_seq[3] = E_T1;
        go_t0(32'hD8000000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            got = outs();
            checks++;
            if (got !== exp_seq[i]) $display("FAIL nop_seq cycle %0d: got %h want %h", i, got, exp_seq[i]);
            else passed++;
        end
        $display("txn nop: ir=D8000000");
    endtask

    task automatic test_halt();
        logic [19:0] got;
        go_t0(32'hE0000000, 1'b1);
        step();
        step();
        got = outs();
        checks++;
        if (got !== E_T2) $display("FAIL halt_t2: got %h want %h", got, E_T2);
        else passed++;
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            got = outs();
            checks++;
            if (got !== E_RESET) $display("FAIL halt_hold cycle %0d: got %h want %h", i, got, E_RESET);
            else passed++;
        end
        clear = 1'b1;
        step();
        got = outs();
        checks++;
        if (got !== E_RESET) $display("FAIL halt_clear: got %h want %h", got, E_RESET);
        else passed++;
        clear = 1'b0;
        step();
        got = outs();
        checks++;
        if (got !== E_T0) $display("FAIL halt_resume: got %h want %h", got, E_T0);
        else passed++;
        $display("txn halt: ir=E0000000 then clear/start");
    endtask

    task automatic test_clear_mid();
        logic [19:0] got;
        go_t0(32'h20000000, 1'b1);
        for (int i = 0; i < 4; i++) step();
        got = outs();
        checks++;
        if (got !== t4_with(3'd2)) $display("FAIL clear_mid_t4: got %h want %h", got, t4_with(3'd2));
        else passed++;
        clear = 1'b1;
        step();
        got = outs();
        checks++;
        if (got !== E_RESET) $display("FAIL clear_mid_reset: got %h want %h", got, E_RESET);
        else passed++;
        clear = 1'b0;
        bus.start = 1'b0;
        step();
        got = outs();
        checks++;
        if (got !== E_RESET) $display("FAIL clear_mid_stay: got %h want %h", got, E_RESET);
        else passed++;
        $display("txn clear during T4 of sub");
    endtask

    task automatic test_bus_rule();
        int drivers;
        go_t0(32'h30000000, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drivers = int'(bus.pco) + int'(bus.mdro) + int'(bus.zlo) + int'(bus.rout);
            checks++;
            if (drivers > 1) $display("FAIL bus_rule cycle %0d: got %0d drivers want <=1", i, drivers);
            else passed++;
            step();
        end
        $display("txn bus rule over or instruction");
    endtask

    task automatic test_mem_wait();
        logic [19:0] got;
        go_t0(32'h18000000, 1'b0);
        step();
`ifdef MEM_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            got = outs();
            checks++;
            if (got !== E_T1_WAIT) $display("FAIL mem_wait_hold cycle %0d: got %h want %h", i, got, E_T1_WAIT);
            else passed++;
            step();
        end
        bus.mem_ready = 1'b1;
        #1;
        got = outs();
        checks++;
        if (got !== E_T1) $display("FAIL mem_wait_ready: got %h want %h", got, E_T1);
        else passed++;
        step();
`else
        got = outs();
        checks++;
        if (got !== E_T1) $display("FAIL mem_ignore_t1: got %h want %h", got, E_T1);
        else passed++;
        step();
`endif
        got = outs();
        checks++;
        if (got !== E_T2) $display("FAIL mem_wait_t2: got %h want %h", got, E_T2);
        else passed++;
        bus.mem_ready = 1'b1;
        $display("txn mem wait: mem_ready low in T1");
    endtask

    initial begin
        clear = 1'b1;
        bus.start = 1'b0;
        bus.ir = 32'h0;
        bus.mem_ready = 1'b1;
        test_reset();
        test_add();
        test_alu_ops();
        test_nop();
        test_halt();
        test_clear_mid();
        test_bus_rule();
        test_mem_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
